// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on input and output.
// Base operations finish in one cycle. MUL/MULHU use iterative shift-add and
// DIVU/REMU use iterative restoring division, one step per cycle for WIDTH cycles.
// Optional feature macro: SEQ_ALU_OVERFLOW_EN adds a registered signed-overflow
// output for ADD/SUB.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [3:0]       ALU_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef SEQ_ALU_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             zero_flag
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, next_state;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   opnd;      // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0]   acc_hi;    // product high half / partial remainder
    logic [WIDTH-1:0]   acc_lo;    // multiplier / dividend, becomes low product or quotient
    logic [SHAMT_W-1:0] cnt;

    logic               start_iter;
    logic [WIDTH-1:0]   base_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rsh;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo, iter_res;
    logic               last_step;

    // Single-cycle operations; DIVU/REMU only reach here for a zero divisor.
    function automatic logic [WIDTH-1:0] base_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
        case (op)
            OP_ADD:  base_op = a + b;
            OP_SUB:  base_op = a - b;
            OP_AND:  base_op = a & b;
            OP_OR:   base_op = a | b;
            OP_XOR:  base_op = a ^ b;
            OP_SLTU: base_op = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  base_op = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  base_op = a << sh;
            OP_SRL:  base_op = a >> sh;
            OP_SRA:  base_op = $unsigned($signed(a) >>> sh);
            OP_DIVU: base_op = '1;
            OP_REMU: base_op = a;
            default: base_op = '0;
        endcase
    endfunction

    // Signed overflow of ADD/SUB, judged from operand and result sign bits.
    function automatic logic ovf_op(input logic [3:0] op,
                                    input logic a_msb,
                                    input logic b_msb,
                                    input logic r_msb);
        case (op)
            OP_ADD:  ovf_op = (a_msb == b_msb) && (r_msb != a_msb);
            OP_SUB:  ovf_op = (a_msb != b_msb) && (r_msb != a_msb);
            default: ovf_op = 1'b0;
        endcase
    endfunction

    // Decode of the incoming op and one iteration step of multiply/divide.
    always_comb begin
        start_iter = (ALU_op == OP_MUL) || (ALU_op == OP_MULHU) ||
                     (((ALU_op == OP_DIVU) || (ALU_op == OP_REMU)) && (in1 != '0));
        base_res   = base_op(ALU_op, in0, in1);

        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_rsh  = {acc_hi, acc_lo[WIDTH-1]};
        div_ge   = (div_rsh >= {1'b0, opnd});
        div_diff = div_rsh[WIDTH-1:0] - opnd;

        if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_diff : div_rsh[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end

        iter_res  = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? step_lo : step_hi;
        last_step = (cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = start_iter ? BUSY : DONE;
            end
            BUSY: begin
                if (last_step) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Iteration counter and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            result    <= '0;
            zero_flag <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (in_valid) begin
                cnt <= '0;
                if (!start_iter) begin
                    result    <= base_res;
                    zero_flag <= (base_res == '0);
`ifdef SEQ_ALU_OVERFLOW_EN
                    overflow  <= ovf_op(ALU_op, in0[WIDTH-1], in1[WIDTH-1], base_res[WIDTH-1]);
`endif
                end
            end
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (last_step) begin
                result    <= iter_res;
                zero_flag <= (iter_res == '0);
`ifdef SEQ_ALU_OVERFLOW_EN
                overflow  <= 1'b0;
`endif
            end
        end
    end

    // Operand latching on accept and per-step update of the working registers.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (in_valid) begin
                op_q   <= ALU_op;
                acc_hi <= '0;
                if ((ALU_op == OP_MUL) || (ALU_op == OP_MULHU)) begin
                    opnd   <= in0;
                    acc_lo <= in1;
                end else begin
                    opnd   <= in1;
                    acc_lo <= in0;
                end
            end
        end else if (state == BUSY) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vectors with literal expectations plus a
// behavioural model checked against the DUT on every cycle.
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero_flag;
    logic [31:0] in0, in1, result;
    logic [3:0]  ALU_op;
    logic        overflow;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero;
    logic [15:0] s_in0, s_in1, s_result;
    logic [3:0]  s_op;
    logic        s_overflow;

    int n_checks = 0;
    int n_errors = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .ALU_op(ALU_op), .out_valid(out_valid),
        .out_ready(out_ready), .result(result),
`ifdef SEQ_ALU_OVERFLOW_EN
        .overflow(overflow),
`endif
        .zero_flag(zero_flag)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in0(s_in0), .in1(s_in1), .ALU_op(s_op), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .result(s_result),
`ifdef SEQ_ALU_OVERFLOW_EN
        .overflow(s_overflow),
`endif
        .zero_flag(s_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU written from the operation definitions using wide arithmetic.
    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return $unsigned($signed(a) >>> b[4:0]);
            4'd10: return prod[31:0];
            4'd11: return prod[63:32];
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_ovf(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic signed [32:0] wide;
        if (op == 4'd0)      wide = $signed({a[31], a}) + $signed({b[31], b});
        else if (op == 4'd1) wide = $signed({a[31], a}) - $signed({b[31], b});
        else                 return 1'b0;
        return (wide > 33'sd2147483647) || (wide < -33'sd2147483648);
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd10 || op == 4'd11) return 32;
        if ((op == 4'd12 || op == 4'd13) && b != 0) return 32;
        return 0;
    endfunction

    // Model state: one transaction in flight, cycles left until its result shows.
    logic        m_busy;
    int          m_wait;
    logic [31:0] m_res;
    logic        m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_wait <= 0;
        end else if (m_busy && m_wait == 0) begin
            if (out_ready) m_busy <= 1'b0;
        end else if (m_busy) begin
            m_wait <= m_wait - 1;
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_wait <= model_lat(ALU_op, in1);
            m_res  <= model_alu(ALU_op, in0, in1);
            m_ovf  <= model_ovf(ALU_op, in0, in1);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one op on the 32-bit DUT, measure latency, check result, then take it.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_zero, input int exp_lat);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_in_ready"}, in_ready, 1'b1);
        in0 = a; in1 = b; ALU_op = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in0 = ~a; in1 = ~b; ALU_op = ~op;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_result"}, result, exp_res);
        chk({name, "_zero"}, zero_flag, exp_zero);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_drop_valid"}, out_valid, 1'b0);
    endtask

    task automatic run16(input string name, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_res,
                         input logic exp_zero, input int exp_lat);
        int n;
        chk({name, "_in_ready"}, s_in_ready, 1'b1);
        s_in0 = a; s_in1 = b; s_op = op; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        n = 1;
        while (!s_out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_result"}, s_result, exp_res);
        chk({name, "_zero"}, s_zero, exp_zero);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in0 = '0; in1 = '0; ALU_op = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_in0 = '0; s_in1 = '0; s_op = '0;

        // Per-cycle comparison against the model.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    chk("cyc_out_valid", out_valid, (m_busy && m_wait == 0));
                    chk("cyc_in_ready", in_ready, !m_busy);
                    if (m_busy && m_wait == 0) begin
                        chk("cyc_result", result, m_res);
                        chk("cyc_zero", zero_flag, (m_res == 0));
`ifdef SEQ_ALU_OVERFLOW_EN
                        chk("cyc_overflow", overflow, m_ovf);
`endif
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", zero_flag, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b1);

        run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1);
`ifdef SEQ_ALU_OVERFLOW_EN
        chk("add_ovf_flag", overflow, 1'b1);
`endif
        run_op("mul_ff", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        run_op("mulhu_ff", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        run_op("mul_small", 4'd10, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, 1'b0, 33);
        run_op("divu_100_7", 4'd12, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        run_op("remu_100_7", 4'd13, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        run_op("divu_7_100", 4'd12, 32'd7, 32'd100, 32'd0, 1'b1, 33);
        run_op("divu_max_1", 4'd12, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("remu_hex", 4'd13, 32'h1234_5678, 32'h0001_0000, 32'h0000_5678, 1'b0, 33);
        run_op("divu_by0", 4'd12, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("remu_by0", 4'd13, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1);
        run_op("sra", 4'd9, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1);
        run_op("srl", 4'd8, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1);
        run_op("sll", 4'd7, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1);
        run_op("slt", 4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
        run_op("sltu", 4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
        run_op("and", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
        run_op("or", 4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1);
        run_op("xor", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1);
        run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1);
`ifdef SEQ_ALU_OVERFLOW_EN
        chk("sub_ovf_flag", overflow, 1'b1);
`endif
        run_op("rsv_e", 4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1);
        run_op("rsv_f", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1);

        // Backpressure: result held while the consumer stalls and inputs churn.
        in0 = 32'd3; in1 = 32'd4; ALU_op = 4'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid0", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid; in0 = $urandom; in1 = $urandom; ALU_op = 4'(i + 1);
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_result", result, 32'd7);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_ready", in_ready, 1'b1);

        // Reset in the middle of a multiply discards it.
        in0 = 32'hFFFF_FFFF; in1 = 32'h0000_0003; ALU_op = 4'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_in_ready", in_ready, 1'b1);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_valid", out_valid, 1'b0);
        run_op("sub_zero", 4'd1, 32'd5, 32'd5, 32'd0, 1'b1, 1);

        // 16-bit instance.
        run16("w16_add", 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1);
        run16("w16_mulhu", 4'd11, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 17);
        run16("w16_divu", 4'd12, 16'd1000, 16'd9, 16'd111, 1'b0, 17);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
